data_mem_responder: RTL
=======================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit storage words.
REQ-002 The block SHALL have parameter WAIT_STATES, default 2, meaning extra cycles between request acceptance and response (0..15).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port req_valid, input, 1 bit: the initiator presents a request.
REQ-006 The block SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-007 The block SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_address, input, REGISTER_WIDTH (32) bits: byte address.
REQ-009 The block SHALL have port req_write_data, input, 32 bits: store data, right-aligned.
REQ-010 The block SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 illegal.
REQ-011 The block SHALL have port req_unsigned, input, 1 bit: a load zero-extends when 1 and sign-extends when 0.
REQ-012 The block SHALL have port rsp_valid, output, 1 bit: a response is available.
REQ-013 The block SHALL have port rsp_ready, input, 1 bit: the initiator accepts the response.
REQ-014 The block SHALL have port rsp_read_data, output, 32 bits: extended load data; 0 for stores and errors.
REQ-015 The block SHALL have port rsp_error, output, 1 bit: the request was rejected.

Function
REQ-016 The block SHALL implement FSM states IDLE, WAIT and RESPOND; req_ready SHALL be 1 only in IDLE; rsp_valid SHALL be 1 only in RESPOND.
REQ-017 In IDLE with req_valid=1, the block SHALL capture all request fields at the edge and go to WAIT, or to RESPOND if WAIT_STATES=0.
REQ-018 WAIT SHALL last exactly WAIT_STATES cycles, using a 4-bit down-counter loaded at acceptance, then go to RESPOND.
REQ-019 rsp_valid SHALL assert at edge N+1+WAIT_STATES, where N is the acceptance edge.
REQ-020 The block SHALL hold rsp_valid, rsp_read_data and rsp_error stable until rsp_valid and rsp_ready are both 1 at an edge, then return to IDLE; req_ready SHALL rise on the following cycle, with no back-to-back acceptance on the completion edge.
REQ-021 The block SHALL flag an error when any of these holds: req_size=11; half access at an odd address; word access not 4-byte aligned; address >= 4*DEPTH_WORDS.
REQ-022 On error, the block SHALL perform no write, set rsp_read_data=0 and set rsp_error=1.
REQ-023 Storage SHALL be little-endian; the word index SHALL be address[31:2] and the byte lane address[1:0].
REQ-024 A store SHALL modify only the addressed lanes: byte updates 1 lane from write_data[7:0]; half updates 2 lanes from write_data[15:0]; word updates 4 lanes.
REQ-025 A store SHALL commit exactly once, on the edge entering RESPOND, and SHALL produce rsp_read_data=0 and rsp_error=0.
REQ-026 A load SHALL read the word on the edge entering RESPOND, select the lane(s), extend them to 32 bits per req_unsigned, and register the result into rsp_read_data.
REQ-027 While the block is busy (WAIT or RESPOND), it SHALL ignore req_valid and all request inputs; changes to them SHALL NOT alter the response in flight.
REQ-028 A load following a store to the same address SHALL return the stored data.

Reset
REQ-029 While rst=0, the block SHALL hold state=IDLE, counter=0, rsp_valid=0, rsp_error=0, rsp_read_data=0 and req_ready=0.
REQ-030 req_ready SHALL be 1 on the first cycle after rst is deasserted.
REQ-031 Storage contents SHALL NOT be reset.
REQ-032 If reset asserts during WAIT, the pending store SHALL be discarded with no write; if it asserts during RESPOND, the store SHALL already have been committed.

Verification
REQ-033 Word store then load: store 0xDEADBEEF to 0x10, then load word from 0x10 -> rsp_read_data=0xDEADBEEF, rsp_error=0, rsp_valid 3 cycles after acceptance (WAIT_STATES=2).
REQ-034 Byte and half extension: with word 0x10 = 0xDEADBEEF, load byte from 0x13 signed -> 0xFFFFFFDE; unsigned -> 0x000000DE; load half from 0x10 signed -> 0xFFFFBEEF.
REQ-035 Partial store: store byte 0x55 to 0x11 -> word 0x10 reads 0xDEADBE55... no: reads 0xDEAD55EF; other lanes unchanged.
REQ-036 Errors: word load at 0x12; half store at 0x11; any access at 0x400 (DEPTH_WORDS=256); req_size=11 -> rsp_error=1, rsp_read_data=0, memory unchanged.
REQ-037 Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and data stable, req_ready=0 throughout; on handshake, req_ready=1 on the next cycle.
REQ-038 Reset mid-operation: assert rst during WAIT of a store of 0x12345678 to 0x20 -> outputs cleared asynchronously, and a subsequent load of 0x20 returns the prior value.

Source files
------------

// File: rtl/data_mem_responder_if.sv
// Request/response bus between an initiator and the data memory responder.
// The initiator drives requests and rsp_ready; the responder drives the rest.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_address;
  logic [31:0] req_write_data;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_read_data;
  logic        rsp_error;

  modport master (
    output req_valid, req_write, req_address, req_write_data, req_size, req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_read_data, rsp_error
  );

  modport slave (
    input  req_valid, req_write, req_address, req_write_data, req_size, req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_read_data, rsp_error
  );
endinterface

// File: rtl/data_mem_responder.sv
// Little-endian word-organised data memory with byte/half/word access,
// a fixed wait-state delay and a held valid/ready response.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);
  localparam int          NUM_LANES = 4;
  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT     = 33'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, uns_q;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept, commit, use_in;
  logic        e_wr, e_uns, err;
  logic [31:0] e_addr, e_wdata;
  logic [1:0]  e_size;
  logic [IDX_W-1:0]     idx;
  logic [NUM_LANES-1:0] mask;
  logic [31:0] wlane, rd_word, sh, ld;

  assign bus.req_ready     = (state_q == IDLE) & rst;
  assign bus.rsp_valid     = (state_q == RESPOND);
  assign bus.rsp_read_data = rdata_q;
  assign bus.rsp_error     = err_q;

  // With zero wait states the commit happens on the acceptance edge, so the
  // live bus fields are used; otherwise the captured copy is.
  assign use_in  = (state_q == IDLE);
  assign e_wr    = use_in ? bus.req_write      : wr_q;
  assign e_uns   = use_in ? bus.req_unsigned   : uns_q;
  assign e_addr  = use_in ? bus.req_address    : addr_q;
  assign e_wdata = use_in ? bus.req_write_data : wdata_q;
  assign e_size  = use_in ? bus.req_size       : size_q;
  assign idx     = e_addr[IDX_W+1:2];

  always_comb begin
    err = 1'b0;
    case (e_size)
      2'b00:   err = 1'b0;
      2'b01:   err = e_addr[0];
      2'b10:   err = |e_addr[1:0];
      default: err = 1'b1;
    endcase
    if ({1'b0, e_addr} >= LIMIT) err = 1'b1;
  end

  always_comb begin
    mask  = 4'b1111;
    wlane = e_wdata;
    case (e_size)
      2'b00: begin
        mask  = 4'b0001 << e_addr[1:0];
        wlane = {4{e_wdata[7:0]}};
      end
      2'b01: begin
        mask  = 4'b0011 << e_addr[1:0];
        wlane = {2{e_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  assign rd_word = mem[idx];
  assign sh      = rd_word >> {e_addr[1:0], 3'b000};

  always_comb begin
    ld = sh;
    case (e_size)
      2'b00:   ld = {{24{~e_uns & sh[7]}},  sh[7:0]};
      2'b01:   ld = {{16{~e_uns & sh[15]}}, sh[15:0]};
      default: ld = sh;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: if (bus.req_valid && bus.req_ready) begin
        accept = 1'b1;
        if (WAIT_STATES == 0) begin
          state_d = RESPOND;
          commit  = 1'b1;
        end else begin
          state_d = WAIT;
          cnt_d   = 4'(WAIT_STATES);
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESPOND;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESPOND: if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= bus.req_write;
        uns_q   <= bus.req_unsigned;
        addr_q  <= bus.req_address;
        wdata_q <= bus.req_write_data;
        size_q  <= bus.req_size;
      end
      if (commit) begin
        rdata_q <= (err || e_wr) ? 32'h0 : ld;
        err_q   <= err;
      end
    end
  end

  // Storage is never reset; commit is already gated by the reset-held state.
  always_ff @(posedge clk) begin
    if (commit && e_wr && !err) begin
      for (int l = 0; l < NUM_LANES; l++)
        if (mask[l]) mem[idx][8*l +: 8] <= wlane[8*l +: 8];
    end
  end
endmodule
